reverb_feedback_mix: RTL and testbench
======================================

// Module: reverb_feedback_mix
// PURPOSE
//  Feedback side of the reverb delay line: takes dry samples and the delayed
//  samples read back from the delay FIFO, and forms out = dry + decay*delayed.
//  The mixed result goes to the audio output and is also written back into the
//  delay FIFO, which turns the single echo into a decaying reverb.
//  Owns all delay-FIFO control (write, read, flush) and the fill/priming sequence.
// PARAMETERS
//  DATA_W    16    signed sample width (dry, delayed, mix)
//  GAIN_W    8     unsigned decay width; gain = decay/256
//  DELAY_W   13    width of delay_num
//  MAX_DELAY 4096  largest supported delay in samples; delay_num is clamped to this
// PORTS
//  clk        in   1        system clock
//  reset      in   1        synchronous, active-high reset
//  in_valid   in   1        one-cycle sample strobe
//  in         in   DATA_W   dry sample, signed
//  delay_num  in   DELAY_W  delay length in samples
//  decay      in   GAIN_W   feedback gain
//  dly_q      in   DATA_W   delay FIFO read data; valid 1 cycle after dly_rd_en
//  dly_wr_en  out  1        delay FIFO write strobe
//  dly_data   out  DATA_W   delay FIFO write data (the mix)
//  dly_rd_en  out  1        delay FIFO read strobe
//  dly_flush  out  1        delay FIFO clear request
//  out        out  DATA_W   mixed sample, signed
//  out_valid  out  1        one-cycle strobe, aligned with out
//  primed     out  1        high while in RUN (delayed samples are live)
//  overrun    out  1        sticky; set when in_valid arrives with the pipe busy
// BEHAVIOUR
//  Reset: state=IDLE. out, dly_data and all counters are 0. out_valid, dly_wr_en,
//   dly_rd_en, primed and overrun are 0. dly_flush=1 for every cycle reset is high.
//  Clamp rule: dnum = min(delay_num, MAX_DELAY).
//  FSM
//   IDLE -> BYPASS if dnum==0; otherwise latch dnum, set fill_cnt=0, go FILL.
//   FILL: each sample is written with feedback=0, so out=dry. fill_cnt increments
//    on each write; at fill_cnt==dnum go RUN.
//   RUN: on in_valid, dly_rd_en pulses at T0 and the full mix path is active.
//   BYPASS: out=dry; no FIFO traffic; nothing is written.
//   Live change: if dnum differs from the latched value in FILL, RUN or BYPASS,
//    pulse dly_flush for 1 cycle, drop primed, and go to IDLE on the next cycle.
//  Pipeline, in_valid at cycle T0:
//   T0  register dry; in RUN also pulse dly_rd_en.
//   T1  capture dly_q; use 0 outside RUN.
//   T2  prod = dly_q * $signed({1'b0,decay}), 25 bits; scaled = prod >>> 8
//       (arithmetic shift, floor).
//   T3  sum = dry + scaled, 17 bits; saturate to [-32768, 32767]. Register out;
//       pulse out_valid. In FILL/RUN also pulse dly_wr_en with dly_data=out.
//   Latency is exactly 3 cycles from in_valid to out_valid.
//  Spacing: in_valid must be at least 4 cycles apart. An in_valid while the pipe
//   is busy is dropped (no FIFO strobes) and sets overrun; only reset clears it.
//  Write and read strobes never share a cycle for the same sample, so the FIFO
//   occupancy stays at exactly dnum in RUN.
//  Reset mid-operation discards in-flight samples; no out_valid after reset.
// STRUCTURE
//  Shared package reverb_pkg: DATA_W, GAIN_W, DELAY_W, MAX_DELAY; the state enum
//   {IDLE, FILL, RUN, BYPASS}; SAT_MAX/SAT_MIN constants.
//  One sub-module: reverb_sat_mul (T1-T3 multiply, shift, add, saturate; 3 stages).
//  FSM, counters and FIFO strobes stay in the top level.
// TESTING
//  1 dnum=4, decay=128, impulse 1000 then zeros; FIFO model returns writes
//    FIFO-ordered -> out 1000, 0,0,0, 500, 0,0,0, 250, ...; primed rises after 4 writes.
//  2 dnum=0, in=1234 -> out=1234 at T0+3; dly_wr_en/dly_rd_en never pulse.
//  3 RUN, dry=30000, dly_q=30000, decay=255 -> out=32767; dry=-30000, dly_q=-30000
//    -> out=-32768; dly_q=-1, decay=1, dry=0 -> out=-1 (floor).
//  4 in_valid 2 cycles after a prior strobe -> dropped, overrun=1, FIFO strobe count
//    unchanged.
//  5 In RUN, change delay_num 4->6 -> one dly_flush pulse, primed=0, refill of
//    6 samples, primed=1.
//  6 Assert reset at T0+2 of a sample -> no out_valid; dly_flush=1 during reset;
//    all outputs 0 after.

Source files
------------

// File: rtl/reverb_pkg.sv
// Shared constants, state encoding and helpers for the reverb feedback mixer.
package reverb_pkg;

  localparam int DATA_W    = 16;
  localparam int GAIN_W    = 8;
  localparam int DELAY_W   = 13;
  localparam int MAX_DELAY = 4096;
  localparam int PROD_W    = DATA_W + GAIN_W + 1;
  localparam int SUM_W     = DATA_W + 1;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, RUN, BYPASS} state_t;

  function automatic logic [DELAY_W-1:0] clamp_delay(input logic [DELAY_W-1:0] d);
    return (d > DELAY_W'(MAX_DELAY)) ? DELAY_W'(MAX_DELAY) : d;
  endfunction

endpackage

// File: rtl/reverb_sat_mul.sv
// Feedback datapath: scale the delayed sample by decay/256 (floor), add the dry
// sample and saturate. Product registered at T1->T2, saturated mix at T2->T3.
module reverb_sat_mul
  import reverb_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_mul,
  input  logic                     en_sum,
  input  logic signed [DATA_W-1:0] dry,
  input  logic signed [DATA_W-1:0] dly,
  input  logic        [GAIN_W-1:0] decay,
  output logic signed [DATA_W-1:0] mix
);

  logic signed [PROD_W-1:0] prod_q;
  logic signed [DATA_W-1:0] dry_q;
  logic signed [SUM_W-1:0]  scaled;
  logic signed [SUM_W-1:0]  sum;
  logic signed [DATA_W-1:0] sat;

  always_comb begin
    scaled = SUM_W'(prod_q >>> 8);
    sum    = $signed({dry_q[DATA_W-1], dry_q}) + scaled;
    if (sum > SUM_W'(SAT_MAX))      sat = SAT_MAX;
    else if (sum < SUM_W'(SAT_MIN)) sat = SAT_MIN;
    else                            sat = DATA_W'(sum);
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset as well, so out/dly_data read 0 after reset.
    if (reset) begin
      prod_q <= '0;
      dry_q  <= '0;
      mix    <= '0;
    end else begin
      if (en_mul) begin
        prod_q <= PROD_W'(dly) * PROD_W'($signed({1'b0, decay}));
        dry_q  <= dry;
      end
      if (en_sum) mix <= sat;
    end
  end

endmodule

// File: rtl/reverb_feedback_mix.sv
// Reverb feedback mixer: out = dry + decay*delayed, written back into the delay
// FIFO. Owns the FIFO strobes, the fill/priming FSM and live delay changes.
module reverb_feedback_mix
  import reverb_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in,
  input  logic        [DELAY_W-1:0] delay_num,
  input  logic        [GAIN_W-1:0]  decay,
  input  logic signed [DATA_W-1:0]  dly_q,
  output logic                      dly_wr_en,
  output logic signed [DATA_W-1:0]  dly_data,
  output logic                      dly_rd_en,
  output logic                      dly_flush,
  output logic signed [DATA_W-1:0]  out,
  output logic                      out_valid,
  output logic                      primed,
  output logic                      overrun
);

  state_t             state, state_nxt;
  logic [DELAY_W-1:0] dnum, dnum_lat, fill_cnt;
  logic               changing, busy, accept;
  logic               v1, v2, run1, wr1, wr2, wr3;
  logic signed [DATA_W-1:0] dry_q;

  assign dnum      = clamp_delay(delay_num);
  assign changing  = (state != IDLE) && (dnum != dnum_lat);
  assign busy      = v1 | v2 | out_valid;
  assign accept    = in_valid && !busy;
  assign dly_rd_en = accept && (state == RUN) && !changing && !reset;
  // A write still in flight when the delay changes must not land after the flush.
  assign dly_wr_en = wr3 && !changing && !reset;
  assign dly_flush = reset || changing;
  assign primed    = (state == RUN);
  assign dly_data  = out;

  always_comb begin
    // NOTE: default first, so no branch leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:        state_nxt = (dnum == '0) ? BYPASS : FILL;
      FILL: begin
        if (changing) state_nxt = IDLE;
        else if (dly_wr_en && (fill_cnt + DELAY_W'(1) == dnum_lat)) state_nxt = RUN;
      end
      RUN, BYPASS: if (changing) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking, so every register samples the old value of the others.
    if (reset) begin
      state    <= IDLE;
      dnum_lat <= '0;
      fill_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        dnum_lat <= dnum;
        fill_cnt <= '0;
      end else if (state == FILL && dly_wr_en) begin
        fill_cnt <= fill_cnt + DELAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      run1      <= 1'b0;
      wr1       <= 1'b0;
      wr2       <= 1'b0;
      wr3       <= 1'b0;
      dry_q     <= '0;
      overrun   <= 1'b0;
    end else begin
      v1        <= accept;
      v2        <= v1;
      out_valid <= v2;
      run1      <= dly_rd_en;
      wr1       <= accept && (state == FILL || state == RUN) && !changing;
      wr2       <= wr1 && !changing;
      wr3       <= wr2 && !changing;
      if (accept) dry_q <= in;
      if (in_valid && busy) overrun <= 1'b1;
    end
  end

  reverb_sat_mul u_sat_mul (
    .clk    (clk),
    .reset  (reset),
    .en_mul (v1),
    .en_sum (v2),
    .dry    (dry_q),
    .dly    (run1 ? dly_q : '0),
    .decay  (decay),
    .mix    (out)
  );

endmodule

// File: tb/tb_reverb_feedback_mix.sv
// Bench for reverb_feedback_mix: FIFO model around the DUT, and a reference
// y[n] = sat(x[n] + floor(y[n-d]*g/256)) (y[n] = x[n] while priming).
module tb_reverb_feedback_mix;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] in = '0;
  logic        [12:0] delay_num = '0;
  logic        [7:0]  decay = '0;
  logic signed [15:0] dly_q = '0;
  logic               dly_wr_en, dly_rd_en, dly_flush, out_valid, primed, overrun;
  logic signed [15:0] dly_data, out;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, flush_cnt = 0;
  logic signed [15:0] fifo[$];
  logic signed [15:0] outs[$];
  logic signed [15:0] ys[$];
  int                 xs[$];

  reverb_feedback_mix dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .delay_num(delay_num), .decay(decay), .dly_q(dly_q),
    .dly_wr_en(dly_wr_en), .dly_data(dly_data), .dly_rd_en(dly_rd_en),
    .dly_flush(dly_flush), .out(out), .out_valid(out_valid),
    .primed(primed), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Delay FIFO: read data appears one cycle after dly_rd_en.
  always @(posedge clk) begin
    if (dly_flush) fifo.delete();
    else begin
      if (dly_rd_en) begin
        if (fifo.size() > 0) dly_q <= fifo.pop_front();
        else dly_q <= '0;
      end
      if (dly_wr_en) fifo.push_back(dly_data);
    end
  end

  always @(negedge clk) begin
    if (out_valid) outs.push_back(out);
    if (dly_wr_en) wr_cnt++;
    if (dly_rd_en) rd_cnt++;
    if (dly_flush) flush_cnt++;
  end

  function automatic logic signed [15:0] sat16(input int v);
    if (v > 32767) return 16'sh7fff;
    if (v < -32768) return 16'sh8000;
    return 16'(v);
  endfunction

  function automatic void build_expect(input int d, input int g);
    ys.delete();
    for (int n = 0; n < xs.size(); n++) begin
      int v;
      if (d == 0 || n < d) v = xs[n];
      else v = xs[n] + ((int'(ys[n-d]) * g) >>> 8);
      ys.push_back(sat16(v));
    end
  endfunction

  function automatic int rnd_sample();
    return int'($signed(16'($urandom)));
  endfunction

  task automatic send(input int x);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in = 16'(x);
    xs.push_back(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int d, input int g);
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    delay_num = 13'(d);
    decay = 8'(g);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs.delete();
    xs.delete();
    ys.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    delay_num = 13'd4;
    decay = 8'd128;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dly_flush, out_valid, dly_wr_en, dly_rd_en, primed, overrun} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags got %b want 100000",
               {dly_flush, out_valid, dly_wr_en, dly_rd_en, primed, overrun});
    end
    checks++;
    if (out !== 16'sd0 || dly_data !== 16'sd0) begin
      errors++;
      $display("FAIL reset_data got out=%0d dly_data=%0d want 0", out, dly_data);
    end
  endtask

  task automatic test_echo();
    do_reset(4, 128);
    for (int i = 0; i < 12; i++) begin
      send(i == 0 ? 1000 : 0);
      if (i == 2 || i == 3) begin
        checks++;
        if (primed !== (i == 3)) begin
          errors++;
          $display("FAIL echo_primed after %0d writes got %b want %b", i + 1, primed, i == 3);
        end
      end
    end
    build_expect(4, 128);
    checks++;
    if (outs.size() != ys.size()) begin
      errors++;
      $display("FAIL echo_count got %0d want %0d", outs.size(), ys.size());
    end
    foreach (ys[i]) if (i < outs.size()) begin
      checks++;
      if (outs[i] !== ys[i]) begin
        errors++;
        $display("FAIL echo[%0d] got %0d want %0d", i, outs[i], ys[i]);
      end
    end
  endtask

  task automatic test_bypass();
    int wr0, rd0, fl0;
    do_reset(0, 77);
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in = 16'sd1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (t == 3)) begin
        errors++;
        $display("FAIL bypass_latency T%0d out_valid got %b want %b", t, out_valid, t == 3);
      end
    end
    checks++;
    if (out !== 16'sd1234) begin
      errors++;
      $display("FAIL bypass_out got %0d want 1234", out);
    end
    repeat (2) @(negedge clk);
    outs.delete();
    for (int i = 0; i < 6; i++) send(rnd_sample());
    build_expect(0, 77);
    checks++;
    if (outs.size() != ys.size()) begin
      errors++;
      $display("FAIL bypass_count got %0d want %0d", outs.size(), ys.size());
    end
    foreach (ys[i]) if (i < outs.size()) begin
      checks++;
      if (outs[i] !== ys[i]) begin
        errors++;
        $display("FAIL bypass[%0d] got %0d want %0d", i, outs[i], ys[i]);
      end
    end
    checks++;
    if (wr_cnt != wr0 || rd_cnt != rd0) begin
      errors++;
      $display("FAIL bypass_fifo_strobes got wr=%0d rd=%0d want 0 0", wr_cnt - wr0, rd_cnt - rd0);
    end
    // Both 5000 and 8191 clamp to 4096, so only the 0 -> 5000 change flushes.
    fl0 = flush_cnt;
    @(posedge clk); #1;
    delay_num = 13'd5000;
    repeat (4) @(posedge clk); #1;
    delay_num = 13'd8191;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (flush_cnt - fl0 != 1 || primed !== 1'b0) begin
      errors++;
      $display("FAIL clamp_flush got flushes=%0d primed=%b want 1 0", flush_cnt - fl0, primed);
    end
  endtask

  task automatic test_saturate();
    int gs[3] = '{255, 255, 1};
    int x0[3] = '{30000, -30000, -1};
    int x1[3] = '{30000, -30000, 0};
    int want[3] = '{32767, -32768, -1};
    for (int k = 0; k < 3; k++) begin
      do_reset(1, gs[k]);
      send(x0[k]);
      send(x1[k]);
      checks++;
      if (outs.size() != 2 || outs[1] !== 16'(want[k])) begin
        errors++;
        $display("FAIL sat_%0d got %0d (n=%0d) want %0d", k,
                 (outs.size() > 1) ? int'(outs[1]) : 0, outs.size(), want[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int d, g;
      d = $urandom_range(1, 7);
      g = $urandom_range(0, 255);
      do_reset(d, g);
      for (int i = 0; i < 3 * d + 6; i++) send(rnd_sample());
      build_expect(d, g);
      checks++;
      if (outs.size() != ys.size()) begin
        errors++;
        $display("FAIL rand%0d_count got %0d want %0d", it, outs.size(), ys.size());
      end
      foreach (ys[i]) if (i < outs.size()) begin
        checks++;
        if (outs[i] !== ys[i]) begin
          errors++;
          $display("FAIL rand%0d[%0d] d=%0d g=%0d got %0d want %0d", it, i, d, g, outs[i], ys[i]);
        end
      end
      checks++;
      if (fifo.size() != d) begin
        errors++;
        $display("FAIL rand%0d_occupancy got %0d want %0d", it, fifo.size(), d);
      end
    end
  endtask

  task automatic test_overrun();
    int wr0, rd0, n0, xa;
    do_reset(2, 100);
    for (int i = 0; i < 3; i++) send(rnd_sample());
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_before got %b want 0", overrun);
    end
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    n0 = outs.size();
    xa = rnd_sample();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in = 16'(xa);
    xs.push_back(xa);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in = 16'sd4321;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b want 1", overrun);
    end
    checks++;
    if (wr_cnt - wr0 != 1 || rd_cnt - rd0 != 1 || outs.size() - n0 != 1) begin
      errors++;
      $display("FAIL overrun_drop got wr=%0d rd=%0d outs=%0d want 1 1 1",
               wr_cnt - wr0, rd_cnt - rd0, outs.size() - n0);
    end
    for (int i = 0; i < 3; i++) send(rnd_sample());
    build_expect(2, 100);
    foreach (ys[i]) begin
      checks++;
      if (i >= outs.size() || outs[i] !== ys[i]) begin
        errors++;
        $display("FAIL overrun_mix[%0d] got %0d want %0d", i,
                 (i < outs.size()) ? int'(outs[i]) : 0, ys[i]);
      end
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky got %b want 1", overrun);
    end
  endtask

  task automatic test_live_change();
    int fl0;
    do_reset(4, 128);
    for (int i = 0; i < 6; i++) send(rnd_sample());
    fl0 = flush_cnt;
    @(posedge clk); #1;
    delay_num = 13'd6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (flush_cnt - fl0 != 1 || primed !== 1'b0) begin
      errors++;
      $display("FAIL live_flush got flushes=%0d primed=%b want 1 0", flush_cnt - fl0, primed);
    end
    outs.delete();
    xs.delete();
    for (int i = 0; i < 12; i++) begin
      send(rnd_sample());
      if (i == 4 || i == 5) begin
        checks++;
        if (primed !== (i == 5)) begin
          errors++;
          $display("FAIL live_primed after %0d refills got %b want %b", i + 1, primed, i == 5);
        end
      end
    end
    build_expect(6, 128);
    foreach (ys[i]) begin
      checks++;
      if (i >= outs.size() || outs[i] !== ys[i]) begin
        errors++;
        $display("FAIL live_mix[%0d] got %0d want %0d", i,
                 (i < outs.size()) ? int'(outs[i]) : 0, ys[i]);
      end
    end
    checks++;
    if (fifo.size() != 6) begin
      errors++;
      $display("FAIL live_occupancy got %0d want 6", fifo.size());
    end
  endtask

  task automatic test_reset_midflight();
    int n0;
    do_reset(4, 128);
    for (int i = 0; i < 5; i++) send(rnd_sample());
    n0 = outs.size();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in = 16'sd1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dly_flush !== 1'b1) begin
      errors++;
      $display("FAIL midreset_flush got %b want 1", dly_flush);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, dly_wr_en, dly_rd_en, primed, overrun} !== 5'b0 ||
        out !== 16'sd0 || dly_data !== 16'sd0) begin
      errors++;
      $display("FAIL midreset_outputs got flags=%b out=%0d dly_data=%0d want 0",
               {out_valid, dly_wr_en, dly_rd_en, primed, overrun}, out, dly_data);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (outs.size() != n0) begin
      errors++;
      $display("FAIL midreset_no_out got %0d extra outputs want 0", outs.size() - n0);
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_bypass();
    test_saturate();
    test_random();
    test_overrun();
    test_live_change();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
